// File: rtl/tv80_bus_tracer.sv
// tv80_bus_tracer
//   Passive observer on the tv80s bus pins. Each completed bus cycle becomes a
//   record {kind[2:0], addr[15:0], data[7:0], ts[TS_W-1:0]}. Records are queued
//   in a DEPTH-entry FIFO and drained over a valid/ready port. An instruction
//   counter treats DD/FD/CB/ED prefixes as part of the instruction they precede.
// Ports
//   clk, reset_n           core clock, asynchronous active-low reset
//   cen                    clock enable; the bus is sampled only when cen=1
//   m1_n .. rfsh_n, A      core bus strobes and address
//   di / dout              read data into the core / write data out of it
//   rec_valid/ready/data   record FIFO head, popped on valid & ready
//   overflow, drop_cnt     sticky drop flag, saturating drop counter
//   inst_cnt               instructions started (wraps)
// Kind codes: 0 OPFETCH, 1 MEMRD, 2 MEMWR, 3 IORD, 4 IOWR, 5 INTACK.
module tv80_bus_tracer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cen,
  input  logic              m1_n,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              rfsh_n,
  input  logic [15:0]       A,
  input  logic [7:0]        di,
  input  logic [7:0]        dout,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [26+TS_W:0]  rec_data,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  output logic [15:0]       inst_cnt
);

  localparam int unsigned REC_W = 27 + TS_W;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    K_OP   = 3'd0,
    K_MRD  = 3'd1,
    K_MWR  = 3'd2,
    K_IORD = 3'd3,
    K_IOWR = 3'd4,
    K_INTA = 3'd5,
    K_NONE = 3'd7
  } kind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_COMMIT
  } state_t;

  state_t            state;
  kind_t             cur_kind;
  logic [15:0]       cur_addr;
  logic [7:0]        cur_data;
  logic [TS_W-1:0]   cur_ts;
  logic [TS_W-1:0]   ts;
  logic              prefix_pend;

  kind_t             samp_kind;
  logic [7:0]        samp_data;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              start_rec;
  logic [REC_W-1:0]  push_rec;

  logic [REC_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  // Bus decode in priority order; refresh cycles are never recorded.
  always_comb begin
    samp_kind = K_NONE;
    if (rfsh_n) begin
      if (!m1_n && !iorq_n)                samp_kind = K_INTA;
      else if (!m1_n && !mreq_n && !rd_n)  samp_kind = K_OP;
      else if (!mreq_n && !rd_n)           samp_kind = K_MRD;
      else if (!mreq_n && !wr_n)           samp_kind = K_MWR;
      else if (!iorq_n && !rd_n)           samp_kind = K_IORD;
      else if (!iorq_n && !wr_n)           samp_kind = K_IOWR;
    end
    samp_data = (samp_kind == K_MWR || samp_kind == K_IOWR) ? dout : di;
  end

  always_comb begin
    push_req  = 1'b0;
    start_rec = 1'b0;
    if (cen) begin
      unique case (state)
        S_IDLE: begin
          start_rec = (samp_kind != K_NONE);
        end
        S_ACTIVE: begin
          // A change of kind with no idle gap closes the old record and opens a new one.
          push_req  = (samp_kind != K_NONE) && (samp_kind != cur_kind);
          start_rec = push_req;
        end
        S_COMMIT: begin
          push_req  = 1'b1;
          start_rec = (samp_kind != K_NONE);
        end
        default: ;
      endcase
    end
    push_rec = {cur_kind, cur_addr, cur_data, cur_ts};
    full     = (count == FULL_CNT);
    pop      = rec_valid && rec_ready;
    push_ok  = push_req && (!full || pop);
  end

  // Cycle-assembly FSM, timestamp and instruction counter; frozen while cen=0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cur_kind    <= K_OP;
      cur_addr    <= '0;
      cur_data    <= '0;
      cur_ts      <= '0;
      ts          <= '0;
      prefix_pend <= 1'b0;
      inst_cnt    <= '0;
    end else if (cen) begin
      ts <= ts + 1'b1;

      unique case (state)
        S_IDLE:   state <= (samp_kind != K_NONE) ? S_ACTIVE : S_IDLE;
        S_ACTIVE: state <= (samp_kind == K_NONE) ? S_COMMIT : S_ACTIVE;
        S_COMMIT: state <= (samp_kind != K_NONE) ? S_ACTIVE : S_IDLE;
        default:  state <= S_IDLE;
      endcase

      if (start_rec) begin
        cur_kind <= samp_kind;
        cur_addr <= A;
        cur_data <= samp_data;
        cur_ts   <= ts;
      end else if (state == S_ACTIVE && samp_kind == cur_kind) begin
        // Last asserted sample wins, so late-settling read data is captured.
        cur_data <= samp_data;
      end

      // Counted on every push attempt, so dropped records still count.
      if (push_req) begin
        if (cur_kind == K_OP) begin
          if (!prefix_pend) inst_cnt <= inst_cnt + 16'd1;
          prefix_pend <= (cur_data == 8'hDD) || (cur_data == 8'hFD) ||
                         (cur_data == 8'hCB) || (cur_data == 8'hED);
        end else if (cur_kind == K_INTA) begin
          prefix_pend <= 1'b0;
        end
      end
    end
  end

  // FIFO control. Pops follow the consumer handshake independently of cen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_rec;
  end

  always_comb begin
    rec_valid = (count != '0);
    rec_data  = rec_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_tv80_bus_tracer.sv
module tb_tv80_bus_tracer;

  localparam int DEPTH = 16;
  localparam int TS_W  = 16;
  localparam int REC_W = 27 + TS_W;

  localparam logic [2:0] K_OP   = 3'd0;
  localparam logic [2:0] K_MRD  = 3'd1;
  localparam logic [2:0] K_MWR  = 3'd2;
  localparam logic [2:0] K_IORD = 3'd3;
  localparam logic [2:0] K_IOWR = 3'd4;
  localparam logic [2:0] K_INTA = 3'd5;

  logic             clk;
  logic             reset_n;
  logic             cen;
  logic             m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0]      A;
  logic [7:0]       di, dout;
  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;
  logic             overflow;
  logic [7:0]       drop_cnt;
  logic [15:0]      inst_cnt;

  tv80_bus_tracer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset_n(reset_n), .cen(cen),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .A(A), .di(di), .dout(dout),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .overflow(overflow), .drop_cnt(drop_cnt), .inst_cnt(inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: counts enabled clocks since reset.
  logic [TS_W-1:0] tcnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tcnt <= '0;
    else if (cen) tcnt <= tcnt + 1'b1;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [REC_W-1:0] expq[$];

  typedef struct {
    int unsigned grp;
    logic [2:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_pins();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic set_pins(input logic [2:0] k, input logic [15:0] a, input logic [7:0] v);
    idle_pins();
    A = a;
    case (k)
      K_OP:   begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
      K_MRD:  begin mreq_n = 1'b0; rd_n = 1'b0; end
      K_MWR:  begin mreq_n = 1'b0; wr_n = 1'b0; end
      K_IORD: begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IOWR: begin iorq_n = 1'b0; wr_n = 1'b0; end
      K_INTA: begin m1_n = 1'b0; iorq_n = 1'b0; end
      default: ;
    endcase
    // The unused data bus carries the complement to expose a wrong data select.
    if (k == K_MWR || k == K_IOWR) begin dout = v; di = ~v; end
    else begin di = v; dout = ~v; end
  endtask

  // One Z80-shaped bus cycle starting at a negedge; the first active sample
  // carries stale data so only the last sample's value is correct.
  task automatic bus_cycle(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d);
    int unsigned na;
    logic [REC_W-1:0] rec;
    na  = (k == K_IORD || k == K_IOWR) ? 3 : 2;
    rec = {k, a, d, tcnt};
    for (int unsigned i = 0; i < na; i++) begin
      set_pins(k, a, (i == na - 1) ? d : ~d);
      @(negedge clk);
    end
    if (k == K_OP) begin
      idle_pins();
      A = 16'h0040; mreq_n = 1'b0; rfsh_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end else begin
      idle_pins();
      @(negedge clk);
    end
    if (expq.size() < DEPTH) expq.push_back(rec);
  endtask

  task automatic idle_clks(input int unsigned n);
    idle_pins();
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; cen = 1'b1; rec_ready = 1'b0;
    idle_pins(); A = '0; di = '0; dout = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expq.delete();
  endtask

  task automatic drain(input string name);
    int unsigned idx = 0;
    while (expq.size() > 0) begin
      int unsigned w = 0;
      while (!rec_valid && w < 8) begin @(negedge clk); w++; end
      chk($sformatf("%s rec_valid[%0d]", name, idx), 64'(rec_valid), 64'd1);
      chk($sformatf("%s rec_data[%0d]", name, idx), 64'(rec_data), 64'(expq[0]));
      void'(expq.pop_front());
      rec_ready = 1'b1;
      @(negedge clk);
      rec_ready = 1'b0;
      idx++;
    end
    chk($sformatf("%s empty", name), 64'(rec_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [REC_W-1:0] r;
    logic [TS_W-1:0]  t0;
    int unsigned inst_exp [4];

    // grp0: DD CB F7 71 with IX=1B33 reads (IX-9)=1B2A
    vt.push_back('{0, K_OP,   16'h0000, 8'hDD});
    vt.push_back('{0, K_OP,   16'h0001, 8'hCB});
    vt.push_back('{0, K_MRD,  16'h0002, 8'hF7});
    vt.push_back('{0, K_MRD,  16'h0003, 8'h71});
    vt.push_back('{0, K_MRD,  16'h1B2A, 8'h08});
    // grp1: LD (8000),A with A=5A
    vt.push_back('{1, K_OP,   16'h0000, 8'h32});
    vt.push_back('{1, K_MRD,  16'h0001, 8'h00});
    vt.push_back('{1, K_MRD,  16'h0002, 8'h80});
    vt.push_back('{1, K_MWR,  16'h8000, 8'h5A});
    // grp2: OUT (7F),A ; IN A,(7F) with A=3C
    vt.push_back('{2, K_OP,   16'h0000, 8'hD3});
    vt.push_back('{2, K_MRD,  16'h0001, 8'h7F});
    vt.push_back('{2, K_IOWR, 16'h3C7F, 8'h3C});
    vt.push_back('{2, K_OP,   16'h0002, 8'hDB});
    vt.push_back('{2, K_MRD,  16'h0003, 8'h7F});
    vt.push_back('{2, K_IORD, 16'h3C7F, 8'h3C});
    // grp3: DD DD 21 nn nn ; FD, INTACK, 00 ; ED B0
    vt.push_back('{3, K_OP,   16'h0000, 8'hDD});
    vt.push_back('{3, K_OP,   16'h0001, 8'hDD});
    vt.push_back('{3, K_OP,   16'h0002, 8'h21});
    vt.push_back('{3, K_MRD,  16'h0003, 8'h34});
    vt.push_back('{3, K_MRD,  16'h0004, 8'h12});
    vt.push_back('{3, K_OP,   16'h0005, 8'hFD});
    vt.push_back('{3, K_INTA, 16'h0006, 8'hFF});
    vt.push_back('{3, K_OP,   16'h0038, 8'h00});
    vt.push_back('{3, K_OP,   16'h0039, 8'hED});
    vt.push_back('{3, K_OP,   16'h003A, 8'hB0});
    inst_exp = '{1, 1, 2, 4};

    reset_n = 1'b0; cen = 1'b1; rec_ready = 1'b0;
    idle_pins(); A = '0; di = '0; dout = '0;
    #1;
    chk("reset rec_valid", 64'(rec_valid), 64'd0);
    chk("reset rec_data",  64'(rec_data),  64'd0);
    chk("reset overflow",  64'(overflow),  64'd0);
    chk("reset drop_cnt",  64'(drop_cnt),  64'd0);
    chk("reset inst_cnt",  64'(inst_cnt),  64'd0);

    for (int unsigned g = 0; g < 4; g++) begin
      do_reset();
      for (int unsigned i = 0; i < vt.size(); i++)
        if (vt[i].grp == g) bus_cycle(vt[i].kind, vt[i].addr, vt[i].data);
      idle_clks(2);
      chk($sformatf("grp%0d inst_cnt", g), 64'(inst_cnt), 64'(inst_exp[g]));
      chk($sformatf("grp%0d overflow", g), 64'(overflow), 64'd0);
      drain($sformatf("grp%0d", g));
    end

    // Release-to-valid latency of two clocks.
    do_reset();
    t0 = tcnt;
    set_pins(K_MRD, 16'h1234, 8'h77);
    @(negedge clk);
    idle_pins();
    @(negedge clk);
    chk("latency valid@1", 64'(rec_valid), 64'd0);
    @(negedge clk);
    chk("latency valid@2", 64'(rec_valid), 64'd1);
    r = {K_MRD, 16'h1234, 8'h77, t0};
    chk("latency rec_data", 64'(rec_data), 64'(r));
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;

    // Kind change with no idle sample in between.
    t0 = tcnt;
    set_pins(K_MRD, 16'h2000, 8'h11);
    @(negedge clk);
    expq.push_back({K_MRD, 16'h2000, 8'h11, t0});
    t0 = tcnt;
    set_pins(K_MWR, 16'h2001, 8'h22);
    @(negedge clk);
    expq.push_back({K_MWR, 16'h2001, 8'h22, t0});
    idle_clks(3);
    drain("b2b");

    // cen=0 freezes the FSM even though the strobes drop mid-cycle.
    t0 = tcnt;
    set_pins(K_MRD, 16'h3000, 8'h44);
    @(negedge clk);
    cen = 1'b0;
    idle_pins();
    @(negedge clk);
    @(negedge clk);
    chk("cen hold ts", 64'(tcnt), 64'(t0 + 1'b1));
    cen = 1'b1;
    set_pins(K_MRD, 16'h3000, 8'h44);
    @(negedge clk);
    idle_clks(3);
    expq.push_back({K_MRD, 16'h3000, 8'h44, t0});
    drain("cen");

    // Refresh with read strobe asserted must not be recorded.
    A = 16'h0055; mreq_n = 1'b0; rd_n = 1'b0; rfsh_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    idle_clks(3);
    chk("rfsh no record", 64'(rec_valid), 64'd0);

    // 40 NOPs into a 16-deep FIFO with no consumer.
    do_reset();
    for (int unsigned i = 0; i < 40; i++) bus_cycle(K_OP, 16'(i), 8'h00);
    idle_clks(2);
    chk("ovf overflow", 64'(overflow), 64'd1);
    chk("ovf drop_cnt", 64'(drop_cnt), 64'd24);
    chk("ovf inst_cnt", 64'(inst_cnt), 64'd40);
    chk("ovf rec_valid", 64'(rec_valid), 64'd1);

    // Full FIFO, pop coincident with push: accepted without a drop.
    t0 = tcnt;
    set_pins(K_OP, 16'h0028, 8'h00);
    @(negedge clk);
    @(negedge clk);
    idle_pins(); A = 16'h0041; mreq_n = 1'b0; rfsh_n = 1'b0;
    @(negedge clk);
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;
    void'(expq.pop_front());
    expq.push_back({K_OP, 16'h0028, 8'h00, t0});
    idle_clks(2);
    chk("fullpop drop_cnt", 64'(drop_cnt), 64'd24);
    chk("fullpop inst_cnt", 64'(inst_cnt), 64'd41);
    drain("fullpop");
    chk("fullpop overflow sticky", 64'(overflow), 64'd1);

    // Reset in the middle of a memory write discards it.
    bus_cycle(K_MRD, 16'h4000, 8'h99);
    idle_clks(2);
    set_pins(K_MWR, 16'h5000, 8'hAB);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst rec_valid", 64'(rec_valid), 64'd0);
    chk("midrst rec_data",  64'(rec_data),  64'd0);
    chk("midrst overflow",  64'(overflow),  64'd0);
    chk("midrst drop_cnt",  64'(drop_cnt),  64'd0);
    chk("midrst inst_cnt",  64'(inst_cnt),  64'd0);
    idle_pins();
    @(negedge clk);
    reset_n = 1'b1;
    expq.delete();
    bus_cycle(K_OP, 16'h0100, 8'h3E);
    idle_clks(2);
    chk("midrst first ts", 64'(rec_data[TS_W-1:0]), 64'd0);
    drain("midrst");
    chk("midrst inst_cnt after", 64'(inst_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
